mult_share_controller: RTL and testbench

Sequencing and arbitration front-end for one `twos_complement_multiplier` instance. Two requesters share the multiplier through valid/ready handshakes. The controller grants requesters round-robin, latches operands, and issues a single-cycle start pulse. It then waits for an edge-qualified done, returns the signed product tagged with the requester ID, and aborts with a timeout flag if done never arrives.

---
 rtl/mult_share_controller.sv | 157 +++++++++++++++
 tb/tb_mult_share_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_controller.sv
// mult_share_controller
//
// Arbitration and sequencing front-end that lets two requesters share a
// single two's complement multiplier. Requests are granted round-robin,
// operands are latched and presented to the multiplier, a one-cycle start
// pulse is issued, and the product is returned tagged with the owner's ID.
// If the multiplier never signals completion the operation is aborted and a
// zero product is returned with the timeout flag set.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req0_valid/a/b, req0_ready    requester 0 handshake and operands
//   req1_valid/a/b, req1_ready    requester 1 handshake and operands
//   rsp_valid, rsp_ready          response handshake
//   rsp_id, rsp_product           owner of the result, signed 2N+1 product
//   rsp_timeout                   result is an abort (product forced to 0)
//   mul_multiplicand/multiplier   operands to the multiplier
//   mul_start                     single-cycle start pulse
//   mul_done, mul_product         completion and product from the multiplier
//   busy                          high whenever the FSM is not idle
module mult_share_controller #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N:0]   rsp_product,
    output logic           rsp_timeout,
    output logic [N-1:0]   mul_multiplicand,
    output logic [N-1:0]   mul_multiplier,
    output logic           mul_start,
    input  logic           mul_done,
    input  logic [2*N:0]   mul_product,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } state_t;

    localparam int CW = $clog2(TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [CW-1:0]   cnt;
    logic            armed;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            done_ok;
    logic            expire;

    // On a tie the requester that was not served last wins.
    assign grant0 = req0_valid && (!req1_valid || last);
    assign grant1 = req1_valid && (!req0_valid || !last);

    // Combinational handshakes are gated by reset so every output reads 0
    // while reset is held, even before the state register has been cleared.
    assign req0_ready = rst && (state == IDLE) && grant0;
    assign req1_ready = rst && (state == IDLE) && grant1;
    assign mul_start  = rst && (state == START);
    assign rsp_valid  = rst && (state == RESP);

    assign accept  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    // A done that was already high when the operation started (left over
    // from the previous product) only counts after it has been seen low.
    assign done_ok = mul_done && armed;
    assign expire  = (cnt == CW'(TIMEOUT - 1));

    // Operands only change on accept, so they are stable from LOAD to the
    // end of WAIT.
    assign mul_multiplicand = op_a;
    assign mul_multiplier   = op_b;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (done_ok || expire) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            last        <= 1'b1;
            op_a        <= '0;
            op_b        <= '0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
            armed       <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req0_ready) begin
                            op_a   <= req0_a;
                            op_b   <= req0_b;
                            rsp_id <= 1'b0;
                            last   <= 1'b0;
                        end else begin
                            op_a   <= req1_a;
                            op_b   <= req1_b;
                            rsp_id <= 1'b1;
                            last   <= 1'b1;
                        end
                    end
                end
                START: begin
                    cnt   <= '0;
                    armed <= 1'b0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (!mul_done) armed <= 1'b1;
                    // Completion takes priority over a coincident timeout.
                    if (done_ok) begin
                        rsp_product <= mul_product;
                        rsp_timeout <= 1'b0;
                    end else if (expire) begin
                        rsp_product <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_controller.sv
// Testbench for mult_share_controller (N=8, TIMEOUT=16).
// Contains a behavioural multiplier stub with programmable completion latency
// and stale-done behaviour, a vector table of single operations, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_mult_share_controller;

    localparam int N  = 8;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_timeout;
    logic [2*N:0]  rsp_product;
    logic [N-1:0]  mul_multiplicand, mul_multiplier;
    logic          mul_start, mul_done, busy;
    logic [2*N:0]  mul_product;

    mult_share_controller #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_timeout(rsp_timeout),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_start(mul_start), .mul_done(mul_done), .mul_product(mul_product),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[16:0];
    endfunction

    // Multiplier stub: t counts cycles since the start pulse. done is held
    // high for the first mdl_stale cycles (left over from the last product)
    // and rises for good at t == mdl_lat (0 = never).
    int mdl_lat   = 0;
    int mdl_stale = 0;
    int mdl_t     = 1000;
    initial begin
        mul_done    = 1'b0;
        mul_product = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                mdl_t       = 0;
                mul_product = ref_mul(mul_multiplicand, mul_multiplier);
            end else if (mdl_t < 100000) begin
                mdl_t++;
            end
            mul_done = (mdl_t < mdl_stale) || (mdl_lat != 0 && mdl_t >= mdl_lat);
        end
    end

    int  start_bad  = 0;
    logic prev_start = 1'b0;
    initial forever begin
        @(negedge clk);
        #2;
        if (mul_start && (prev_start || !busy)) start_bad++;
        prev_start = mul_start;
    end

    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input int stale, input int bp,
                          input logic [16:0] exp_p, input logic exp_to, input string nm);
        int   t_acc, t_start, t_rsp;
        logic got;
        @(negedge clk);
        mdl_lat   = lat;
        mdl_stale = stale;
        rsp_ready = (bp == 0);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        #1;
        got = 1'b0;
        t_acc = 0;
        for (int k = 0; k < 20; k++) begin
            if ((id == 0) ? req0_ready : req1_ready) begin
                got = 1'b1; t_acc = cyc; break;
            end
            @(negedge clk); #1;
        end
        chk({nm, " accept"}, got, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        t_start = -1;
        t_rsp   = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (mul_start && t_start < 0) t_start = cyc;
            if (rsp_valid) begin
                t_rsp = cyc; break;
            end
            @(negedge clk);
        end
        chk({nm, " start cycle"}, t_start, t_acc + 2);
        chk({nm, " rsp cycle"}, t_rsp, t_start + (exp_to ? TO + 1 : lat + 1));
        chk({nm, " rsp fields"}, {rsp_id, rsp_timeout, rsp_product}, {id[0], exp_to, exp_p});
        for (int k = 0; k < bp; k++) begin
            @(negedge clk); #1;
            chk({nm, " hold"}, {rsp_valid, rsp_id, rsp_timeout, rsp_product},
                {1'b1, id[0], exp_to, exp_p});
        end
        if (bp > 0) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            #1;
            chk({nm, " valid until ready"}, rsp_valid, 1'b1);
        end
        @(negedge clk); #1;
        chk({nm, " back to idle"}, {rsp_valid, busy}, 2'b00);
    endtask

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [16:0] exp_p;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic        id;
        logic [16:0] p;
        logic        to;
    } rsp_t;

    vec_t vecs[8];
    rsp_t sb[$];
    int   grants[$];

    initial begin
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'h5A; req0_b = 8'hA5; req1_a = 8'h3C; req1_b = 8'hC3;
        rsp_ready = 1'b1;

        vecs[0] = '{0, 8'h8F, 8'h1F, 10, 17'h1F251, 1'b0};
        vecs[1] = '{1, 8'h7F, 8'h7F, 3,  17'h03F01, 1'b0};
        vecs[2] = '{0, 8'h80, 8'h80, 5,  17'h04000, 1'b0};
        vecs[3] = '{1, 8'h80, 8'h7F, 2,  17'h1C080, 1'b0};
        vecs[4] = '{0, 8'hFF, 8'h01, 16, 17'h1FFFF, 1'b0};
        vecs[5] = '{1, 8'h00, 8'h55, 7,  17'h00000, 1'b0};
        vecs[6] = '{0, 8'h12, 8'h34, 0,  17'h00000, 1'b1};
        vecs[7] = '{1, 8'h12, 8'h34, 17, 17'h00000, 1'b1};

        // Reset with both requesters pushing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("reset ctrl/product", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_timeout,
                busy, mul_start, rsp_product}, 32'h0);
            chk("reset operands", {mul_multiplicand, mul_multiplier}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("first idle grant", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].lat, 0, 0,
                   vecs[i].exp_p, vecs[i].exp_to, $sformatf("vec%0d", i));

        // Previous op leaves done high; it stays up for 2 WAIT cycles.
        run_op(0, 8'h05, 8'hFD, 8, 3, 0, 17'h1FFF1, 1'b0, "stale done");
        run_op(1, 8'h40, 8'hC0, 4, 0, 5, 17'h1F000, 1'b0, "backpressure");

        // Reset while req0's operation is in WAIT.
        @(negedge clk);
        mdl_lat = 12; mdl_stale = 0;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h11; rsp_ready = 1'b1;
        #1;
        chk("rst_mid accept", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_mid in wait", {busy, mul_start, rsp_valid}, 3'b100);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid cleared", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_timeout,
            busy, mul_start, rsp_product}, 32'h0);
        rst = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk); #1;
                if (rsp_valid || busy) seen++;
            end
            chk("rst_mid no response", seen, 0);
        end

        // Round-robin with both requesters continuously valid.
        begin
            logic [7:0] a0[2], b0[2], a1[2], b1[2];
            int i0, i1, nr;
            a0[0] = 8'h11; b0[0] = 8'h22; a0[1] = 8'hF0; b0[1] = 8'h0F;
            a1[0] = 8'h33; b1[0] = 8'h44; a1[1] = 8'h81; b1[1] = 8'h02;
            i0 = 0; i1 = 0; nr = 0;
            mdl_lat = 4;
            for (int c = 0; c < 200 && nr < 4; c++) begin
                @(negedge clk);
                req0_valid = (i0 < 2);
                req0_a = a0[i0 % 2]; req0_b = b0[i0 % 2];
                req1_valid = (i1 < 2);
                req1_a = a1[i1 % 2]; req1_b = b1[i1 % 2];
                rsp_ready = 1'b1;
                #1;
                if (req0_valid && req0_ready) begin
                    grants.push_back(0);
                    sb.push_back('{1'b0, ref_mul(req0_a, req0_b), 1'b0});
                    i0++;
                end
                if (req1_valid && req1_ready) begin
                    grants.push_back(1);
                    sb.push_back('{1'b1, ref_mul(req1_a, req1_b), 1'b0});
                    i1++;
                end
                if (rsp_valid) begin
                    chk("rr rsp pending", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        chk("rr rsp", {rsp_id, rsp_timeout, rsp_product}, {sb[0].id, sb[0].to, sb[0].p});
                        void'(sb.pop_front());
                    end
                    nr++;
                end
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk("rr responses", nr, 4);
            chk("rr grant count", grants.size(), 4);
            for (int g = 0; g < 4; g++)
                if (g < grants.size()) chk($sformatf("rr grant %0d", g), grants[g], g % 2);
        end

        // Randomized traffic against a transaction-level model.
        begin
            logic       pend[2];
            logic [7:0] ra[2], rb[2];
            logic       free, last_sv, e0, e1, hs;
            int         lat;
            pend[0] = 1'b0; pend[1] = 1'b0;
            ra[0] = 0; rb[0] = 0; ra[1] = 0; rb[1] = 0;
            free = 1'b1; last_sv = 1'b1;
            sb.delete();
            for (int c = 0; c < 1500; c++) begin
                if (c >= 800 && !pend[0] && !pend[1] && sb.size() == 0 && free) break;
                @(negedge clk);
                for (int r = 0; r < 2; r++)
                    if (c < 800 && !pend[r] && $urandom_range(0, 2) == 0) begin
                        pend[r] = 1'b1;
                        ra[r] = 8'($urandom);
                        rb[r] = 8'($urandom);
                    end
                req0_valid = pend[0]; req0_a = ra[0]; req0_b = rb[0];
                req1_valid = pend[1]; req1_a = ra[1]; req1_b = rb[1];
                rsp_ready = (c >= 800) || ($urandom_range(0, 3) != 0);
                #1;
                e0 = free && pend[0] && (!pend[1] || last_sv);
                e1 = free && pend[1] && (!pend[0] || !last_sv);
                chk("rnd ready", {req0_ready, req1_ready}, {e0, e1});
                hs = 1'b0;
                if (rsp_valid) begin
                    chk("rnd rsp pending", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        chk("rnd rsp", {rsp_id, rsp_timeout, rsp_product}, {sb[0].id, sb[0].to, sb[0].p});
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            hs = 1'b1;
                        end
                    end
                end
                if ((req0_ready && pend[0]) || (req1_ready && pend[1])) begin
                    int id;
                    id = req0_ready ? 0 : 1;
                    lat = $urandom_range(2, 20);
                    mdl_lat = lat;
                    mdl_stale = 0;
                    if (lat <= TO) sb.push_back('{id[0], ref_mul(ra[id], rb[id]), 1'b0});
                    else sb.push_back('{id[0], 17'h0, 1'b1});
                    free = 1'b0;
                    last_sv = id[0];
                    pend[id] = 1'b0;
                end
                if (hs) free = 1'b1;
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk("rnd drained", sb.size() + int'(pend[0]) + int'(pend[1]), 0);
        end

        chk("start pulse shape", start_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
